// File: rtl/vx_fpu_sqrt_iter.sv
// Multi-lane iterative FP32 square root: non-restoring digit recurrence, lanes in lockstep,
// full RISC-V rounding and IEEE flags behind a single-request valid/ready handshake.
module vx_fpu_sqrt_iter #(
    parameter int NUM_LANES      = 1,
    parameter int TAG_WIDTH      = 1,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [NUM_LANES-1:0]     mask_in,
    input  logic [TAG_WIDTH-1:0]     tag_in,
    input  logic [2:0]               frm,
    input  logic [NUM_LANES*32-1:0]  dataa,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [NUM_LANES*32-1:0]  result,
    output logic [4:0]               fflags,
    output logic [TAG_WIDTH-1:0]     tag_out
);
    localparam int          N     = 26 / BITS_PER_CYCLE;
    localparam logic [4:0]  N_CNT = 5'(N);
    localparam logic [31:0] QNAN  = 32'h7FC00000;

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_radix
        $error("vx_fpu_sqrt_iter: BITS_PER_CYCLE must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, PACK = 2'd2, DONE = 2'd3} state_e;

    function automatic logic [4:0] lzc24(input logic [23:0] x);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (x[i]) n = 5'(23 - i);
            else      n = n;
        end
        return n;
    endfunction

    state_e                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [NUM_LANES-1:0]   mask_q;
    logic [TAG_WIDTH-1:0]   tag_q, tag_out_q;
    logic [2:0]             frm_q;
    logic [NUM_LANES*32-1:0] result_q, pack_res_s;
    logic [4:0]             fflags_q, pack_flags_s;
    logic                   accept_s;

    logic [51:0]            rad_q [NUM_LANES], rad_d [NUM_LANES], prep_rad_s [NUM_LANES];
    logic signed [31:0]     rem_q [NUM_LANES], rem_d [NUM_LANES];
    logic [25:0]            root_q [NUM_LANES], root_d [NUM_LANES];
    logic [7:0]             rexp_q [NUM_LANES], prep_exp_s [NUM_LANES];
    logic [31:0]            sres_q [NUM_LANES], prep_sres_s [NUM_LANES];
    logic                   spec_q [NUM_LANES], prep_spec_s [NUM_LANES];
    logic                   snv_q [NUM_LANES], prep_snv_s [NUM_LANES];

    assign ready_in  = (state_q == IDLE) | ((state_q == DONE) & ready_out);
    assign accept_s  = valid_in & ready_in;
    assign valid_out = valid_q;
    assign result    = result_q;
    assign fflags    = fflags_q;
    assign tag_out   = tag_out_q;

    // Operand classification, subnormal normalisation and radicand alignment per lane
    always_comb begin
        logic              sgn;
        logic [7:0]        ex;
        logic [22:0]       fr;
        logic [4:0]        lz;
        logic [23:0]       m24;
        logic signed [9:0] e;
        for (int l = 0; l < NUM_LANES; l++) begin
            sgn = dataa[32*l+31];
            ex  = dataa[32*l+23 +: 8];
            fr  = dataa[32*l +: 23];
            lz  = 5'd0;
            m24 = {1'b1, fr};
            e   = $signed({2'b00, ex}) - 10'sd127;
            prep_spec_s[l] = 1'b0;
            prep_sres_s[l] = 32'd0;
            prep_snv_s[l]  = 1'b0;
            if (ex == 8'hFF) begin
                prep_spec_s[l] = 1'b1;
                prep_sres_s[l] = QNAN;
                if (fr != 23'd0)  prep_snv_s[l]  = ~fr[22];
                else if (sgn)     prep_snv_s[l]  = 1'b1;
                else              prep_sres_s[l] = 32'h7F800000;
            end else if (ex == 8'd0 && fr == 23'd0) begin
                prep_spec_s[l] = 1'b1;
                prep_sres_s[l] = {sgn, 31'd0};
            end else if (sgn) begin
                prep_spec_s[l] = 1'b1;
                prep_sres_s[l] = QNAN;
                prep_snv_s[l]  = 1'b1;
            end else if (ex == 8'd0) begin
                lz  = lzc24({1'b0, fr});
                m24 = {1'b0, fr} << lz;
                e   = -10'sd126 - $signed({5'd0, lz});
            end else begin
                m24 = {1'b1, fr};
            end
            // Odd exponents borrow one radicand bit so the halved exponent stays exact
            if (e[0]) begin
                prep_rad_s[l] = {m24, 28'd0};
                e = e - 10'sd1;
            end else begin
                prep_rad_s[l] = {1'b0, m24, 27'd0};
            end
            prep_exp_s[l] = 8'((e >>> 1) + 10'sd127);
        end
    end

    // Non-restoring recurrence: negative remainders are repaired on the next step, not immediately
    always_comb begin
        logic signed [31:0] r, t;
        logic [25:0]        q;
        logic [51:0]        rd;
        for (int l = 0; l < NUM_LANES; l++) begin
            r  = rem_q[l];
            q  = root_q[l];
            rd = rad_q[l];
            for (int b = 0; b < BITS_PER_CYCLE; b++) begin
                t = {r[29:0], rd[51:50]};
                if (!r[31]) r = t - $signed({4'b0000, q, 2'b01});
                else        r = t + $signed({4'b0000, q, 2'b11});
                q  = {q[24:0], ~r[31]};
                rd = {rd[49:0], 2'b00};
            end
            if (accept_s) begin
                rad_d[l]  = prep_rad_s[l];
                rem_d[l]  = 32'sd0;
                root_d[l] = 26'd0;
            end else if (state_q == CALC) begin
                rad_d[l]  = rd;
                rem_d[l]  = r;
                root_d[l] = q;
            end else begin
                rad_d[l]  = rad_q[l];
                rem_d[l]  = rem_q[l];
                root_d[l] = root_q[l];
            end
        end
    end

    // Rounding, packing, special-lane mux and flag reduction
    always_comb begin
        logic [25:0]        q;
        logic signed [31:0] r;
        logic               rem_nz, g, s, inexact, inc, lane_nv, lane_nx;
        logic [23:0]        mant;
        logic [7:0]         ex;
        logic [31:0]        lane_res;
        pack_res_s   = '0;
        pack_flags_s = 5'd0;
        for (int l = 0; l < NUM_LANES; l++) begin
            q = root_q[l];
            r = rem_q[l];
            if (r[31]) rem_nz = (r + $signed({5'd0, q, 1'b1})) != 32'sd0;
            else       rem_nz = (r != 32'sd0);
            g       = q[1];
            s       = q[0] | rem_nz;
            inexact = g | s;
            case (frm_q)
                3'd1, 3'd2: inc = 1'b0;
                3'd3:       inc = inexact;
                3'd4:       inc = g;
                default:    inc = g & (s | q[2]);
            endcase
            mant = {1'b0, q[24:2]} + {23'd0, inc};
            ex   = rexp_q[l] + {7'd0, mant[23]};
            if (spec_q[l]) begin
                lane_res = sres_q[l];
                lane_nv  = snv_q[l];
                lane_nx  = 1'b0;
            end else begin
                lane_res = {1'b0, ex, mant[22:0]};
                lane_nv  = 1'b0;
                lane_nx  = inexact;
            end
            if (mask_q[l]) begin
                pack_res_s[32*l +: 32] = lane_res;
                pack_flags_s = pack_flags_s | {lane_nv, 3'b000, lane_nx};
            end else begin
                pack_res_s[32*l +: 32] = 32'd0;
            end
        end
    end

    // Control FSM next state and result-valid
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = CALC;
                    cnt_d   = N_CNT;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = PACK;
                else               state_d = CALC;
            end
            PACK: begin
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE: begin
                if (ready_out) begin
                    valid_d = 1'b0;
                    if (valid_in) begin
                        state_d = CALC;
                        cnt_d   = N_CNT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            valid_q   <= 1'b0;
            mask_q    <= '0;
            tag_q     <= '0;
            frm_q     <= 3'd0;
            result_q  <= '0;
            fflags_q  <= 5'd0;
            tag_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            if (accept_s) begin
                mask_q <= mask_in;
                tag_q  <= tag_in;
                frm_q  <= frm;
            end
            if (state_q == PACK) begin
                result_q  <= pack_res_s;
                fflags_q  <= pack_flags_s;
                tag_out_q <= tag_q;
            end
        end
    end

    // Per-lane datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                rad_q[l]  <= 52'd0;
                rem_q[l]  <= 32'sd0;
                root_q[l] <= 26'd0;
                rexp_q[l] <= 8'd0;
                sres_q[l] <= 32'd0;
                spec_q[l] <= 1'b0;
                snv_q[l]  <= 1'b0;
            end
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            if (accept_s) begin
                rexp_q <= prep_exp_s;
                sres_q <= prep_sres_s;
                spec_q <= prep_spec_s;
                snv_q  <= prep_snv_s;
            end
        end
    end
endmodule

// File: tb/tb_vx_fpu_sqrt_iter.sv
// Directed bench for vx_fpu_sqrt_iter: a 4-lane radix-2 instance and a 1-lane radix-4 instance.
module tb_vx_fpu_sqrt_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         v1, r1_in, vo1, ro1;
    logic [3:0]   m1, t1, to1;
    logic [2:0]   frm1;
    logic [127:0] a1, res1;
    logic [4:0]   ff1;

    logic         v2, r2_in, vo2, ro2, m2;
    logic [3:0]   t2, to2;
    logic [2:0]   frm2;
    logic [31:0]  a2, res2;
    logic [4:0]   ff2;

    int n_checks = 0;
    int n_fail   = 0;

    vx_fpu_sqrt_iter #(.NUM_LANES(4), .TAG_WIDTH(4), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .valid_in(v1), .ready_in(r1_in), .mask_in(m1),
        .tag_in(t1), .frm(frm1), .dataa(a1), .valid_out(vo1), .ready_out(ro1),
        .result(res1), .fflags(ff1), .tag_out(to1));

    vx_fpu_sqrt_iter #(.NUM_LANES(1), .TAG_WIDTH(4), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .valid_in(v2), .ready_in(r2_in), .mask_in(m2),
        .tag_in(t2), .frm(frm2), .dataa(a2), .valid_out(vo2), .ready_out(ro2),
        .result(res2), .fflags(ff2), .tag_out(to2));

    task automatic issue1(input logic [3:0] m, input logic [3:0] t, input logic [2:0] f,
                          input logic [127:0] d);
        int n = 0;
        @(negedge clk);
        v1 = 1'b1; m1 = m; t1 = t; frm1 = f; a1 = d;
        while (!r1_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    task automatic wait1(output int lat);
        lat = 0;
        while (!vo1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({vo1, res1, ff1, to1} !== {1'b0, 128'd0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs1: got vo=%b res=%h ff=%h tag=%h, expected all zero", vo1, res1, ff1, to1);
        end
        n_checks++;
        if ({vo2, res2, ff2, to2} !== {1'b0, 32'd0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs2: got vo=%b res=%h ff=%h tag=%h, expected all zero", vo2, res2, ff2, to2);
        end
        n_checks++;
        if ({r1_in, r2_in} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 11", {r1_in, r2_in});
        end
    endtask

    task automatic test_basic();
        int lat;
        issue1(4'b0001, 4'h3, 3'd0, {96'd0, 32'h40800000});
        wait1(lat);
        n_checks++;
        if (lat !== 27) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, expected 27", lat);
        end
        n_checks++;
        if ({res1, ff1, to1} !== {96'd0, 32'h40000000, 5'h00, 4'h3}) begin
            n_fail++;
            $display("FAIL basic_sqrt4: got res=%h ff=%h tag=%h, expected 40000000 00 3", res1, ff1, to1);
        end
        issue1(4'b0001, 4'h4, 3'd0, {96'd0, 32'h40000000});
        wait1(lat);
        n_checks++;
        if ({res1, ff1, to1} !== {96'd0, 32'h3FB504F3, 5'h01, 4'h4}) begin
            n_fail++;
            $display("FAIL basic_sqrt2_rne: got res=%h ff=%h tag=%h, expected 3FB504F3 01 4", res1, ff1, to1);
        end
    endtask

    task automatic test_rounding();
        logic [2:0]  modes [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] exps  [4] = '{32'h3FB504F3, 32'h3FB504F3, 32'h3FB504F4, 32'h3FB504F3};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue1(4'b0001, 4'(i), modes[i], {96'd0, 32'h40000000});
            wait1(lat);
            n_checks++;
            if ({res1[31:0], ff1} !== {exps[i], 5'h01}) begin
                n_fail++;
                $display("FAIL round_frm%0d: got res=%h ff=%h, expected %h 01", modes[i], res1[31:0], ff1, exps[i]);
            end
        end
    endtask

    task automatic test_specials();
        int lat;
        issue1(4'b1111, 4'h7, 3'd0, {32'h7F800000, 32'h80000000, 32'h7F800001, 32'hBF800000});
        wait1(lat);
        n_checks++;
        if (res1 !== {32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000}) begin
            n_fail++;
            $display("FAIL specials_result: got %h, expected 7F800000800000007FC000007FC00000", res1);
        end
        n_checks++;
        if ({ff1, lat} !== {5'h10, 32'd27}) begin
            n_fail++;
            $display("FAIL specials_flags_latency: got ff=%h lat=%0d, expected 10 27", ff1, lat);
        end
        issue1(4'b0011, 4'h8, 3'd0, {64'd0, 32'h7FC00001, 32'h40800000});
        wait1(lat);
        n_checks++;
        if ({res1, ff1} !== {64'd0, 32'h7FC00000, 32'h40000000, 5'h00}) begin
            n_fail++;
            $display("FAIL specials_qnan: got res=%h ff=%h, expected 7FC00000 40000000 flags 00", res1, ff1);
        end
    endtask

    task automatic test_subnormal_mask();
        int lat;
        issue1(4'b0001, 4'h9, 3'd0, {64'd0, 32'hBF800000, 32'h00000001});
        wait1(lat);
        n_checks++;
        if ({res1, ff1} !== {96'd0, 32'h1A3504F3, 5'h01}) begin
            n_fail++;
            $display("FAIL subnormal_mask: got res=%h ff=%h, expected lane0 1A3504F3 others 0, flags 01", res1, ff1);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        v2 = 1'b1; m2 = 1'b1; t2 = 4'h5; frm2 = 3'd0; a2 = 32'h40800000;
        @(posedge clk);
        #1 v2 = 1'b0;
        lat = 0;
        while (!vo2 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if (lat !== 14) begin
            n_fail++;
            $display("FAIL radix4_latency: got %0d cycles, expected 14", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({vo2, r2_in, res2, ff2, to2} !== {1'b1, 1'b0, 32'h40000000, 5'h00, 4'h5}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vo=%b rdy=%b res=%h ff=%h tag=%h, expected 1 0 40000000 00 5",
                         c, vo2, r2_in, res2, ff2, to2);
            end
        end
        @(negedge clk);
        ro2 = 1'b1; v2 = 1'b1; t2 = 4'h6; frm2 = 3'd3; a2 = 32'h40000000;
        #1;
        n_checks++;
        if (r2_in !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b, expected 1", r2_in);
        end
        @(posedge clk);
        #1 v2 = 1'b0;
        n_checks++;
        if (vo2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid_drop: got %b, expected 0", vo2);
        end
        lat = 0;
        while (!vo2 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if ({lat, res2, ff2, to2} !== {32'd14, 32'h3FB504F4, 5'h01, 4'h6}) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d res=%h ff=%h tag=%h, expected 14 3FB504F4 01 6", lat, res2, ff2, to2);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic seen = 1'b0;
        issue1(4'b0001, 4'hC, 3'd0, {96'd0, 32'h40800000});
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 if (vo1) seen = 1'b1;
        end
        n_checks++;
        if ({seen, r1_in} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_no_output: got seen=%b ready=%b, expected 0 1", seen, r1_in);
        end
        issue1(4'b0001, 4'hA, 3'd0, {96'd0, 32'h40800000});
        wait1(lat);
        n_checks++;
        if ({lat, res1[31:0], ff1, to1} !== {32'd27, 32'h40000000, 5'h00, 4'hA}) begin
            n_fail++;
            $display("FAIL after_abort: got lat=%0d res=%h ff=%h tag=%h, expected 27 40000000 00 A", lat, res1[31:0], ff1, to1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b0; m1 = 4'd0; t1 = 4'd0; frm1 = 3'd0; a1 = 128'd0; ro1 = 1'b1;
        v2 = 1'b0; m2 = 1'b0; t2 = 4'd0; frm2 = 3'd0; a2 = 32'd0; ro2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_subnormal_mask();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
